// File: rtl/vote_collector.sv
// vote_collector: synchronise and debounce five voter buttons, collect votes over a timed round, latch result
// Ports:
//   clk   - system clock, all state on rising edge
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous voter buttons, 1 = pressed
//   start - request to open a round
//   comps - latched vote result, bit i = voter i voted
//   valid - high while comps holds a completed round result
//   done  - one-cycle pulse on entry to HOLD
//   busy  - high while collecting
module vote_collector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic       start,
  output logic [4:0] comps,
  output logic       valid,
  output logic       done,
  output logic       busy
);
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t          r_state, w_next;
  logic [4:0]      r_sync1, r_sync2, r_deb, r_vote, r_comps;
  logic [DW-1:0]   r_cnt [5];
  logic [WW-1:0]   r_win;
  logic            r_done;
  logic [4:0]      w_votes;
  logic            w_close, w_open;
  assign w_votes = r_vote | r_deb;
  // a vote debouncing on the closing cycle is still counted because w_votes uses the live debounced level
  assign w_close = (r_state == COLLECT) && ((r_win == '0) || (&w_votes));
  assign w_open  = start && (r_state != COLLECT);
  always_comb begin
    w_next = r_state;
    if (w_open) w_next = COLLECT;
    else if (w_close) w_next = HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vote  <= '0;
      r_win   <= '0;
      r_comps <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_close;
      if (w_open) begin
        r_vote <= '0;
        r_win  <= WIN_LOAD;
      end else if (r_state == COLLECT) begin
        r_vote <= w_votes;
        r_win  <= (r_win == '0) ? r_win : r_win - 1'b1;
      end
      if (w_close) r_comps <= w_votes;
    end
  end
  assign comps = r_comps;
  assign done  = r_done;
  assign valid = (r_state == HOLD);
  assign busy  = (r_state == COLLECT);
endmodule
